rand_result_tracker: RTL and testbench

- Downstream consumer of the lab1 random-number Top.
- Watches the 4-bit random stream and detects when the generator has stopped, i.e. the value has stayed stable for SETTLE_CYC cycles.
- Commits each final value into a DEPTH-entry history and drives two 7-segment digits showing the selected history entry in decimal.
- Sits between Top's o_random_out and the board's seven-segment pins.

---
 rtl/rand_disp_pkg.sv | 33 +++
 rtl/seg7_decoder.sv | 17 +
 rtl/rand_result_tracker.sv | 145 ++++++++++++++
 tb/tb_rand_result_tracker.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/rand_disp_pkg.sv
// Shared types and constants for the random-result tracker.
// The 7-segment patterns are gfedcba, active-high.
package rand_disp_pkg;

  typedef enum logic {S_WAIT, S_TRACK} state_t;

  localparam int DEF_DATA_W     = 4;
  localparam int DEF_SETTLE_CYC = 8;
  localparam int DEF_DEPTH      = 4;

  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
    7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
  };

  // Splits 0..63 into {tens, ones} with constant compares/subtracts, no divider.
  function automatic logic [7:0] bin_to_bcd2(input logic [5:0] v);
    logic [3:0] tens;
    logic [5:0] rem;
    tens = 4'd0;
    rem  = v;
    for (int k = 6; k >= 1; k--) begin
      if (tens == 4'd0 && v >= 6'(10 * k)) begin
        tens = 4'(k);
        rem  = v - 6'(10 * k);
      end
    end
    return {tens, rem[3:0]};
  endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Combinational single-digit 7-segment decoder with a blank override.
// Out-of-range digits also produce a blank pattern.
module seg7_decoder
  import rand_disp_pkg::*;
(
  input  logic [3:0] i_digit,
  input  logic       i_blank,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    if (!i_blank && i_digit <= 4'd9)
      o_seg = SEG_DIGIT[i_digit];
  end

endmodule

// File: rtl/rand_result_tracker.sv
// Detects when the random stream settles, keeps a short history of settled values
// and shows the selected entry on two 7-segment digits.
// Define RAND_TRACK_SEG_ACTIVE_LOW_EN for inverted (common-anode) segment outputs.
//
//   state   | meaning
//   S_WAIT  | idle; constant data ignored until the value changes
//   S_TRACK | counting consecutive unchanged samples toward a commit
module rand_result_tracker
  import rand_disp_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int SETTLE_CYC = DEF_SETTLE_CYC,
  parameter int DEPTH      = DEF_DEPTH
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [DATA_W-1:0]        i_data,
  input  logic                     i_browse,
  output logic                     o_commit,
  output logic                     o_valid,
  output logic [$clog2(DEPTH)-1:0] o_hist_idx,
  output logic [DATA_W-1:0]        o_result,
  output logic [6:0]               o_seg_tens,
  output logic [6:0]               o_seg_ones
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(SETTLE_CYC);
  localparam int NUM_W = $clog2(DEPTH + 1);

`ifdef RAND_TRACK_SEG_ACTIVE_LOW_EN
  localparam logic [6:0] SEG_POL = 7'h7F;
`else
  localparam logic [6:0] SEG_POL = 7'h00;
`endif

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [DATA_W-1:0]   r_d_prev;
  logic [DATA_W-1:0]   r_hist [DEPTH];
  logic [NUM_W-1:0]    r_num;
  logic [IDX_W-1:0]    r_idx;
  logic                r_commit;
  logic                r_valid;
  logic [DATA_W-1:0]   r_result;
  logic [6:0]          r_seg_tens;
  logic [6:0]          r_seg_ones;

  logic                w_change;
  logic                w_do_commit;
  logic [NUM_W-1:0]    w_idx_inc;
  logic [DATA_W-1:0]   w_sel;
  logic [7:0]          w_bcd;
  logic [6:0]          w_seg_tens;
  logic [6:0]          w_seg_ones;

  assign w_change    = (i_data != r_d_prev);
  assign w_do_commit = (r_state == S_TRACK) && !w_change &&
                       (r_cnt == CNT_W'(SETTLE_CYC - 1));
  assign w_idx_inc   = NUM_W'(r_idx) + NUM_W'(1);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= S_WAIT;
      r_cnt    <= '0;
      r_d_prev <= '0;
      for (int k = 0; k < DEPTH; k++) r_hist[k] <= '0;
      r_num    <= '0;
      r_idx    <= '0;
      r_commit <= 1'b0;
      r_valid  <= 1'b0;
    end else begin
      r_d_prev <= i_data;
      r_commit <= 1'b0;

      case (r_state)
        S_WAIT: begin
          r_cnt <= '0;
          if (w_change) r_state <= S_TRACK;
        end
        S_TRACK: begin
          if (w_change) begin
            r_cnt <= '0;
          end else if (w_do_commit) begin
            r_cnt   <= '0;
            r_state <= S_WAIT;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state <= S_WAIT;
          r_cnt   <= '0;
        end
      endcase

      // Commit takes priority over a coincident browse request.
      if (w_do_commit) begin
        for (int k = DEPTH - 1; k > 0; k--) r_hist[k] <= r_hist[k-1];
        r_hist[0] <= i_data;
        if (r_num != NUM_W'(DEPTH)) r_num <= r_num + NUM_W'(1);
        r_idx    <= '0;
        r_commit <= 1'b1;
        r_valid  <= 1'b1;
      end else if (i_browse && r_num != '0) begin
        r_idx <= (w_idx_inc == r_num) ? '0 : IDX_W'(w_idx_inc);
      end
    end
  end

  assign w_sel = r_hist[r_idx];
  assign w_bcd = bin_to_bcd2(6'(w_sel));

  seg7_decoder u_dec_tens (
    .i_digit (w_bcd[7:4]),
    .i_blank (!r_valid || w_bcd[7:4] == 4'd0),
    .o_seg   (w_seg_tens)
  );

  seg7_decoder u_dec_ones (
    .i_digit (w_bcd[3:0]),
    .i_blank (!r_valid),
    .o_seg   (w_seg_ones)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_result   <= '0;
      r_seg_tens <= SEG_BLANK ^ SEG_POL;
      r_seg_ones <= SEG_BLANK ^ SEG_POL;
    end else begin
      r_result   <= w_sel;
      r_seg_tens <= w_seg_tens ^ SEG_POL;
      r_seg_ones <= w_seg_ones ^ SEG_POL;
    end
  end

  assign o_commit   = r_commit;
  assign o_valid    = r_valid;
  assign o_hist_idx = r_idx;
  assign o_result   = r_result;
  assign o_seg_tens = r_seg_tens;
  assign o_seg_ones = r_seg_ones;

endmodule

// File: tb/tb_rand_result_tracker.sv
// Directed self-checking bench for rand_result_tracker (DATA_W=4, SETTLE_CYC=8, DEPTH=4).
module tb_rand_result_tracker;

`ifdef RAND_TRACK_SEG_ACTIVE_LOW_EN
  localparam logic [6:0] POL = 7'h7F;
`else
  localparam logic [6:0] POL = 7'h00;
`endif
  localparam logic [6:0] E_BLANK = 7'h00 ^ POL;
  localparam logic [6:0] E_D1    = 7'h06 ^ POL;
  localparam logic [6:0] E_D2    = 7'h5B ^ POL;
  localparam logic [6:0] E_D4    = 7'h66 ^ POL;
  localparam logic [6:0] E_D9    = 7'h6F ^ POL;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] data;
  logic       browse;
  logic       commit;
  logic       valid;
  logic [1:0] hidx;
  logic [3:0] result;
  logic [6:0] seg_t;
  logic [6:0] seg_o;

  int checks = 0;
  int errors = 0;
  int commit_cnt = 0;

  always #5 clk = ~clk;

  rand_result_tracker #(.DATA_W(4), .SETTLE_CYC(8), .DEPTH(4)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_data     (data),
    .i_browse   (browse),
    .o_commit   (commit),
    .o_valid    (valid),
    .o_hist_idx (hidx),
    .o_result   (result),
    .o_seg_tens (seg_t),
    .o_seg_ones (seg_o)
  );

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (commit) commit_cnt++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; data = 4'd0; browse = 1'b0;
    tick(3);
    checks++; if (commit !== 1'b0) begin errors++; $display("FAIL reset_commit got %b exp 0", commit); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", valid); end
    checks++; if (hidx !== 2'd0) begin errors++; $display("FAIL reset_idx got %0d exp 0", hidx); end
    checks++; if (result !== 4'd0) begin errors++; $display("FAIL reset_result got %0d exp 0", result); end
    checks++; if (seg_t !== E_BLANK || seg_o !== E_BLANK) begin
      errors++; $display("FAIL reset_seg got %h/%h exp %h", seg_t, seg_o, E_BLANK); end
    rst = 1'b0;
  endtask

  task automatic test_idle_constant;
    commit_cnt = 0;
    tick(50);
    browse = 1'b1; tick(1); browse = 1'b0; tick(1);
    checks++; if (commit_cnt !== 0) begin errors++; $display("FAIL idle_commits got %0d exp 0", commit_cnt); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL idle_valid got %b exp 0", valid); end
    checks++; if (hidx !== 2'd0) begin errors++; $display("FAIL idle_browse_idx got %0d exp 0", hidx); end
    checks++; if (seg_t !== E_BLANK || seg_o !== E_BLANK) begin
      errors++; $display("FAIL idle_seg got %h/%h exp %h", seg_t, seg_o, E_BLANK); end
  endtask

  task automatic test_first_commit;
    data = 4'd3; tick(2);
    data = 4'd9;
    for (int i = 1; i <= 9; i++) begin
      tick(1);
      checks++;
      if (commit !== (i == 9)) begin
        errors++; $display("FAIL commit_timing cycle %0d got %b exp %b", i, commit, (i == 9));
      end
    end
    tick(1);
    checks++; if (result !== 4'd9) begin errors++; $display("FAIL first_result got %0d exp 9", result); end
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL first_valid got %b exp 1", valid); end
    checks++; if (seg_t !== E_BLANK || seg_o !== E_D9) begin
      errors++; $display("FAIL first_seg got %h/%h exp %h/%h", seg_t, seg_o, E_BLANK, E_D9); end
    commit_cnt = 0;
    tick(100);
    checks++; if (commit_cnt !== 0) begin errors++; $display("FAIL no_recommit got %0d exp 0", commit_cnt); end
  endtask

  task automatic test_restart;
    commit_cnt = 0;
    data = 4'd14; tick(5);
    data = 4'd7;  tick(1);
    data = 4'd14; tick(30);
    checks++; if (commit_cnt !== 1) begin errors++; $display("FAIL restart_commits got %0d exp 1", commit_cnt); end
    checks++; if (result !== 4'd14) begin errors++; $display("FAIL restart_result got %0d exp 14", result); end
    checks++; if (seg_t !== E_D1 || seg_o !== E_D4) begin
      errors++; $display("FAIL restart_seg got %h/%h exp %h/%h", seg_t, seg_o, E_D1, E_D4); end
  endtask

  task automatic test_browse;
    logic [3:0] exp_res [5];
    logic [1:0] exp_idx [5];
    exp_res = '{4'd4, 4'd3, 4'd2, 4'd5, 4'd4};
    exp_idx = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    commit_cnt = 0;
    for (int v = 1; v <= 5; v++) begin
      data = 4'(v); tick(12);
    end
    checks++; if (commit_cnt !== 5) begin errors++; $display("FAIL hist_commits got %0d exp 5", commit_cnt); end
    checks++; if (result !== 4'd5 || hidx !== 2'd0) begin
      errors++; $display("FAIL hist_newest got %0d@%0d exp 5@0", result, hidx); end
    for (int i = 0; i < 5; i++) begin
      browse = 1'b1; tick(1); browse = 1'b0; tick(1);
      checks++;
      if (result !== exp_res[i] || hidx !== exp_idx[i]) begin
        errors++; $display("FAIL browse_%0d got %0d@%0d exp %0d@%0d", i, result, hidx, exp_res[i], exp_idx[i]);
      end
    end
    browse = 1'b1; tick(3); browse = 1'b0; tick(1);
    checks++; if (hidx !== 2'd0 || result !== 4'd5) begin
      errors++; $display("FAIL browse_held got %0d@%0d exp 5@0", result, hidx); end
  endtask

  task automatic test_back_to_back;
    data = 4'd11; tick(8);
    browse = 1'b1; tick(1); browse = 1'b0;
    checks++; if (commit !== 1'b1 || hidx !== 2'd0) begin
      errors++; $display("FAIL commit_vs_browse got commit=%b idx=%0d exp 1/0", commit, hidx); end
    tick(1);
    checks++; if (result !== 4'd11 || seg_t !== E_D1 || seg_o !== E_D1) begin
      errors++; $display("FAIL eleven got %0d %h/%h exp 11 %h/%h", result, seg_t, seg_o, E_D1, E_D1); end
    data = 4'd12; tick(5);
    rst = 1'b1; data = 4'd0; tick(1);
    checks++; if (commit !== 1'b0 || valid !== 1'b0 || hidx !== 2'd0 || result !== 4'd0) begin
      errors++; $display("FAIL midreset_state got c=%b v=%b i=%0d r=%0d exp 0", commit, valid, hidx, result); end
    checks++; if (seg_t !== E_BLANK || seg_o !== E_BLANK) begin
      errors++; $display("FAIL midreset_seg got %h/%h exp %h", seg_t, seg_o, E_BLANK); end
    tick(1); rst = 1'b0;
    commit_cnt = 0;
    tick(30);
    checks++; if (commit_cnt !== 0 || valid !== 1'b0) begin
      errors++; $display("FAIL post_reset got commits=%0d valid=%b exp 0/0", commit_cnt, valid); end
    data = 4'd2; tick(12);
    checks++; if (result !== 4'd2 || seg_o !== E_D2 || seg_t !== E_BLANK) begin
      errors++; $display("FAIL post_reset_commit got %0d %h/%h exp 2 %h/%h", result, seg_t, seg_o, E_BLANK, E_D2); end
  endtask

  initial begin
    test_reset();
    test_idle_constant();
    test_first_commit();
    test_restart();
    test_browse();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
